muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Sequences one multiply or divide through the external units: start pulse,
// bounded wait for the unit's done, then a single Hi/Lo commit or an error pulse.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_mult,
    input  logic       op_div,
    input  logic       divisor_zero,
    input  logic       mult_done,
    input  logic       div_done,
    output logic       mult,
    output logic       div,
    output logic       hilo_src,
    output logic       Hi_write,
    output logic       Lo_write,
    output logic       dzero,
    output logic       timeout,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    // Handshake: op_mult/op_div are single-cycle requests honoured only while
    // busy=0 (dropped otherwise); mult_done/div_done are pulses from the
    // selected unit, ignored in the start cycle and whenever the other unit runs.

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MRUN = 3'd1,
        DRUN = 3'd2,
        WB   = 3'd3,
        EXC  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            in_run;
    logic            first_run;
    logic            unit_done;
    logic            limit_hit;
    logic            run_entry;
    logic            timeout_next;

    always_comb begin
        state_next   = state;
        in_run       = (state == MRUN) || (state == DRUN);
        first_run    = in_run && (cnt == '0);
        limit_hit    = (cnt == CW'(TIMEOUT_CYCLES - 1));
        unit_done    = !first_run &&
                       (((state == MRUN) && mult_done) || ((state == DRUN) && div_done));
        timeout_next = 1'b0;

        case (state)
            IDLE: begin
                if (op_mult)
                    state_next = MRUN;
                else if (op_div)
                    state_next = divisor_zero ? EXC : DRUN;
            end
            MRUN, DRUN: begin
                // A done arriving on the final allowed cycle still commits.
                if (unit_done) begin
                    state_next = WB;
                end else if (limit_hit) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
            end
            WB:      state_next = IDLE;
            EXC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        run_entry = (state == IDLE) && ((state_next == MRUN) || (state_next == DRUN));

        mult      = (state == MRUN) && first_run;
        div       = (state == DRUN) && first_run;
        Hi_write  = (state == WB);
        Lo_write  = (state == WB);
        done      = (state == WB);
        dzero     = (state == EXC);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hilo_src <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_next;
            timeout <= timeout_next;
            if (run_entry) begin
                cnt      <= '0;
                hilo_src <= (state_next == DRUN);
            end else if (in_run) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
